// File: rtl/pgm_pkg.sv
// rtl/pgm_pkg.sv - shared constants, types and field helpers for the PGM write stage
// Purpose: word flag codes, cfg op codes, register map, RAM address width,
//          write-FSM state type and cfg-word field accessors.
// Ports:   none (package).
package pgm_pkg;

  // Data/cfg word flag in [133:132]
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  // Cfg op codes: op in [126:124], reply marker in [127:124]
  localparam logic [2:0] OP_WR  = 3'b010;
  localparam logic [2:0] OP_RD  = 3'b001;
  localparam logic [3:0] OP_RSP = 4'b1011;

  // Register map
  localparam logic [31:0] REG_START   = 32'h0002_0000;
  localparam logic [31:0] REG_TIME_LO = 32'h0002_0001;
  localparam logic [31:0] REG_TIME_HI = 32'h0002_0002;
  localparam logic [31:0] REG_TLEN    = 32'h0002_0003;
  localparam logic [31:0] REG_DROP    = 32'h0002_0004;
  localparam logic [31:0] REG_STAT    = 32'h0002_0005;

  localparam int RAM_AW = 7;

  typedef enum logic [1:0] {ST_IDLE, ST_STORE, ST_BYPASS, ST_DROP} wr_state_e;

  // Head-word fields: [111:104] src MID, [103:96] dst MID,
  // [95:64] register address, [31:0] register data.
  function automatic logic [7:0] dst_mid(input logic [133:0] w);
    return w[103:96];
  endfunction

  function automatic logic [31:0] cfg_addr(input logic [133:0] w);
    return w[95:64];
  endfunction

  // Read reply: mark as response, swap src/dst MID, load register value.
  function automatic logic [133:0] cfg_reply(input logic [133:0] w, input logic [31:0] val);
    logic [133:0] r;
    r = w;
    r[127:124] = OP_RSP;
    r[111:104] = w[103:96];
    r[103:96]  = w[111:104];
    r[31:0]    = val;
    return r;
  endfunction

endpackage

// File: rtl/pgm_wr_if.sv
// rtl/pgm_wr_if.sv - data/valid/PHV stream bundle between PGM stages
// Purpose: groups one stream hop (data word, packet-valid, PHV and their strobes)
//          with the almost-full backpressure flowing the other way.
// Ports:   master drives data/valid/phv + strobes, slave drives alf/phv_alf.
interface pgm_wr_if;
  logic [133:0]  data;
  logic          data_wr;
  logic          valid;
  logic          valid_wr;
  logic [1023:0] phv;
  logic          phv_wr;
  logic          alf;
  logic          phv_alf;

  modport master (output data, data_wr, valid, valid_wr, phv, phv_wr,
                  input  alf, phv_alf);
  modport slave  (input  data, data_wr, valid, valid_wr, phv, phv_wr,
                  output alf, phv_alf);
endinterface

// File: rtl/pgm_wr_cfg.sv
// rtl/pgm_wr_cfg.sv - cfg-chain register file and read-reply builder for pgm_wr
// Purpose: consumes 2-word write packets addressed to LMID, answers reads in the
//          same slot, passes everything else through with one cycle of latency.
// Ports:   cin_wr_* / cout_wr_* cfg chain, cin_wr_ready -> cout_wr_ready,
//          template status inputs from the data path, start_reg/sent_time outputs.
module pgm_wr_cfg import pgm_pkg::*; #(
  parameter logic [7:0] LMID = 8'd61
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] cin_wr_data,
  input  logic         cin_wr_data_wr,
  output logic         cout_wr_ready,
  output logic [133:0] cout_wr_data,
  output logic         cout_wr_data_wr,
  input  logic         cin_wr_ready,
  input  logic         template_valid,
  input  logic [7:0]   template_len,
  input  logic [31:0]  drop_cnt,
  input  logic         trunc,
  output logic         start_reg,
  output logic [63:0]  sent_time
);

  logic        skip_tail;  // next word is the tail of a consumed write packet
  logic        is_mine;
  logic [31:0] rd_val;

  assign cout_wr_ready = cin_wr_ready;
  assign is_mine = (cin_wr_data[133:132] == HEAD) && (dst_mid(cin_wr_data) == LMID);

  always_comb begin
    rd_val = 32'hffff_ffff;
    case (cfg_addr(cin_wr_data))
      REG_START:   rd_val = {31'b0, start_reg};
      REG_TIME_LO: rd_val = sent_time[31:0];
      REG_TIME_HI: rd_val = sent_time[63:32];
      REG_TLEN:    rd_val = {24'b0, template_len};
      REG_DROP:    rd_val = drop_cnt;
      REG_STAT:    rd_val = {29'b0, trunc, template_valid, start_reg};
      default:     rd_val = 32'hffff_ffff;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_tail       <= 1'b0;
      cout_wr_data    <= '0;
      cout_wr_data_wr <= 1'b0;
      start_reg       <= 1'b0;
      sent_time       <= '0;
    end else begin
      cout_wr_data_wr <= 1'b0;
      if (cin_wr_data_wr) begin
        if (skip_tail) begin
          skip_tail <= 1'b0;
        end else if (is_mine && cin_wr_data[126:124] == OP_WR) begin
          skip_tail <= 1'b1;
          case (cfg_addr(cin_wr_data))
            // Generation may only start once a complete template is in RAM.
            REG_START:   if (template_valid) start_reg <= cin_wr_data[0];
            REG_TIME_LO: sent_time[31:0]  <= cin_wr_data[31:0];
            REG_TIME_HI: sent_time[63:32] <= cin_wr_data[31:0];
            default: ;
          endcase
        end else if (is_mine && cin_wr_data[126:124] == OP_RD) begin
          cout_wr_data    <= cfg_reply(cin_wr_data, rd_val);
          cout_wr_data_wr <= 1'b1;
        end else begin
          cout_wr_data    <= cin_wr_data;
          cout_wr_data_wr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pgm_wr.sv
// rtl/pgm_wr.sv - PGM front stage: template capture into PGM_RAM and packet bypass
// Purpose: head words to LMID are stored word-by-word into PGM_RAM, other packets
//          are forwarded to pgm_rd with one cycle of latency while not generating.
// Ports:   in_wr (stream from upstream), out_wr (stream to pgm_rd),
//          pgm_bypass_flag/pgm_sent_start_flag/out_wr_sent_time_reg to pgm_rd,
//          wr2ram_* RAM write port, cin_wr_*/cout_wr_* cfg chain.
module pgm_wr import pgm_pkg::*; #(
  parameter             PLATFORM  = "Xilinx",
  parameter logic [7:0] LMID      = 8'd61,
  parameter logic [7:0] NMID      = 8'd62,
  parameter int         RAM_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  pgm_wr_if.slave           in_wr,
  pgm_wr_if.master          out_wr,
  output logic              pgm_bypass_flag,
  output logic              pgm_sent_start_flag,
  output logic [63:0]       out_wr_sent_time_reg,
  output logic              wr2ram_wr,
  output logic [RAM_AW-1:0] wr2ram_addr,
  output logic [143:0]      wr2ram_wdata,
  input  logic [133:0]      cin_wr_data,
  input  logic              cin_wr_data_wr,
  output logic              cout_wr_ready,
  output logic [133:0]      cout_wr_data,
  output logic              cout_wr_data_wr,
  input  logic              cin_wr_ready
);

  localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(RAM_DEPTH - 1);

  // PLATFORM is a vendor tag and NMID only documents the chain order.
  if ($bits(PLATFORM) == 0 || NMID == LMID) begin : g_cfg_note
  end

  wr_state_e         state;
  logic [RAM_AW-1:0] wptr;
  logic [7:0]        template_len;
  logic              template_valid;
  logic              trunc;
  logic [31:0]       drop_cnt;
  logic              start_reg;
  logic              fwd;
  logic [1:0]        flag;

  logic [133:0]      o_data;
  logic              o_data_wr, o_valid, o_valid_wr, o_phv_wr;
  logic [1023:0]     o_phv;

  assign in_wr.alf     = out_wr.alf;
  assign in_wr.phv_alf = out_wr.phv_alf;

  assign out_wr.data     = o_data;
  assign out_wr.data_wr  = o_data_wr;
  assign out_wr.valid    = o_valid;
  assign out_wr.valid_wr = o_valid_wr;
  assign out_wr.phv      = o_phv;
  assign out_wr.phv_wr   = o_phv_wr;

  assign flag = in_wr.data[133:132];

  pgm_wr_cfg #(.LMID(LMID)) u_cfg (
    .clk            (clk),
    .rst_n          (rst_n),
    .cin_wr_data    (cin_wr_data),
    .cin_wr_data_wr (cin_wr_data_wr),
    .cout_wr_ready  (cout_wr_ready),
    .cout_wr_data   (cout_wr_data),
    .cout_wr_data_wr(cout_wr_data_wr),
    .cin_wr_ready   (cin_wr_ready),
    .template_valid (template_valid),
    .template_len   (template_len),
    .drop_cnt       (drop_cnt),
    .trunc          (trunc),
    .start_reg      (start_reg),
    .sent_time      (out_wr_sent_time_reg)
  );

  // A word is forwarded when it opens a foreign packet while idle, or belongs to one.
  always_comb begin
    fwd = 1'b0;
    if (in_wr.data_wr) begin
      if (state == ST_BYPASS)
        fwd = 1'b1;
      else if (state == ST_IDLE && flag == HEAD && dst_mid(in_wr.data) != LMID && !start_reg)
        fwd = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      wptr                <= '0;
      template_len        <= '0;
      template_valid      <= 1'b0;
      trunc               <= 1'b0;
      drop_cnt            <= '0;
      wr2ram_wr           <= 1'b0;
      wr2ram_addr         <= '0;
      wr2ram_wdata        <= '0;
      o_data              <= '0;
      o_data_wr           <= 1'b0;
      o_valid             <= 1'b0;
      o_valid_wr          <= 1'b0;
      o_phv               <= '0;
      o_phv_wr            <= 1'b0;
      pgm_bypass_flag     <= 1'b1;
      pgm_sent_start_flag <= 1'b0;
    end else begin
      pgm_sent_start_flag <= start_reg;
      pgm_bypass_flag     <= ~start_reg;

      o_data_wr  <= fwd;
      o_valid_wr <= fwd & in_wr.valid_wr;
      o_phv_wr   <= fwd & in_wr.phv_wr;
      if (fwd) begin
        o_data  <= in_wr.data;
        o_valid <= in_wr.valid;
      end
      if (fwd && in_wr.phv_wr) o_phv <= in_wr.phv;

      wr2ram_wr <= 1'b0;
      if (in_wr.data_wr) begin
        case (state)
          ST_IDLE: begin
            if (flag == HEAD) begin
              if (start_reg) begin
                // RAM is being read by pgm_rd: nothing may enter or pass.
                if (drop_cnt != 32'hffff_ffff) drop_cnt <= drop_cnt + 32'd1;
                state <= ST_DROP;
              end else if (dst_mid(in_wr.data) == LMID) begin
                wr2ram_wr      <= 1'b1;
                wr2ram_addr    <= '0;
                wr2ram_wdata   <= {10'b0, in_wr.data};
                wptr           <= RAM_AW'(1);
                template_valid <= 1'b0;
                trunc          <= 1'b0;
                state          <= ST_STORE;
              end else begin
                state <= ST_BYPASS;
              end
            end
          end
          ST_STORE: begin
            wr2ram_wr   <= 1'b1;
            wr2ram_addr <= wptr;
            if (flag == TAIL) begin
              wr2ram_wdata   <= {10'b0, in_wr.data};
              template_len   <= {1'b0, wptr} + 8'd1;
              template_valid <= 1'b1;
              state          <= ST_IDLE;
            end else if (wptr == LAST_ADDR) begin
              // RAM full: close the template here with a synthetic tail.
              wr2ram_wdata   <= {10'b0, TAIL, 4'b0, in_wr.data[127:0]};
              template_len   <= {1'b0, LAST_ADDR} + 8'd1;
              template_valid <= 1'b1;
              trunc          <= 1'b1;
              state          <= ST_DROP;
            end else begin
              wr2ram_wdata <= {10'b0, in_wr.data};
              wptr         <= wptr + RAM_AW'(1);
            end
          end
          ST_BYPASS: if (flag == TAIL) state <= ST_IDLE;
          ST_DROP:   if (flag == TAIL) state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pgm_wr.sv
// tb/tb_pgm_wr.sv - self-checking bench for pgm_wr
module tb_pgm_wr;
  import pgm_pkg::*;

  localparam logic [7:0] LMID = 8'd61;
  localparam logic [7:0] SRC  = 8'h10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pgm_wr_if in_if ();
  pgm_wr_if out_if ();

  logic              pgm_bypass_flag, pgm_sent_start_flag;
  logic [63:0]       out_wr_sent_time_reg;
  logic              wr2ram_wr;
  logic [RAM_AW-1:0] wr2ram_addr;
  logic [143:0]      wr2ram_wdata;
  logic [133:0]      cin_wr_data, cout_wr_data;
  logic              cin_wr_data_wr, cout_wr_data_wr, cout_wr_ready, cin_wr_ready;

  pgm_wr #(.LMID(LMID)) dut (
    .clk(clk), .rst_n(rst_n), .in_wr(in_if), .out_wr(out_if),
    .pgm_bypass_flag(pgm_bypass_flag), .pgm_sent_start_flag(pgm_sent_start_flag),
    .out_wr_sent_time_reg(out_wr_sent_time_reg),
    .wr2ram_wr(wr2ram_wr), .wr2ram_addr(wr2ram_addr), .wr2ram_wdata(wr2ram_wdata),
    .cin_wr_data(cin_wr_data), .cin_wr_data_wr(cin_wr_data_wr), .cout_wr_ready(cout_wr_ready),
    .cout_wr_data(cout_wr_data), .cout_wr_data_wr(cout_wr_data_wr), .cin_wr_ready(cin_wr_ready)
  );

  typedef struct { logic [133:0] data; logic valid_wr; logic valid; logic phv_wr; logic [1023:0] phv; } out_exp_t;
  typedef struct { logic [RAM_AW-1:0] addr; logic [143:0] wdata; } ram_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] val; } rd_vec_t;

  out_exp_t     out_q[$];
  ram_exp_t     ram_q[$];
  logic [133:0] cfg_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard side: every DUT output strobe pops one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_if.data_wr) begin
        checks++;
        if (out_q.size() == 0) begin
          errors++; $display("FAIL out_unexpected act=%h exp=none", out_if.data);
        end else begin
          out_exp_t e;
          e = out_q.pop_front();
          if (out_if.data !== e.data || out_if.valid_wr !== e.valid_wr ||
              (e.valid_wr && out_if.valid !== e.valid) || out_if.phv_wr !== e.phv_wr ||
              (e.phv_wr && out_if.phv !== e.phv)) begin
            errors++;
            $display("FAIL out_word act=%h vwr=%b v=%b pwr=%b phv_lo=%h exp=%h vwr=%b v=%b pwr=%b phv_lo=%h",
                     out_if.data, out_if.valid_wr, out_if.valid, out_if.phv_wr, out_if.phv[63:0],
                     e.data, e.valid_wr, e.valid, e.phv_wr, e.phv[63:0]);
          end
        end
      end
      if (wr2ram_wr) begin
        checks++;
        if (ram_q.size() == 0) begin
          errors++; $display("FAIL ram_unexpected act=%h@%0d exp=none", wr2ram_wdata, wr2ram_addr);
        end else begin
          ram_exp_t r;
          r = ram_q.pop_front();
          if (wr2ram_addr !== r.addr || wr2ram_wdata !== r.wdata) begin
            errors++;
            $display("FAIL ram_write act=%h@%0d exp=%h@%0d", wr2ram_wdata, wr2ram_addr, r.wdata, r.addr);
          end
        end
      end
      if (cout_wr_data_wr) begin
        checks++;
        if (cfg_q.size() == 0) begin
          errors++; $display("FAIL cfg_unexpected act=%h exp=none", cout_wr_data);
        end else begin
          logic [133:0] c;
          c = cfg_q.pop_front();
          if (cout_wr_data !== c) begin
            errors++; $display("FAIL cfg_word act=%h exp=%h", cout_wr_data, c);
          end
        end
      end
    end
  end

  function automatic logic [133:0] mk_word(input logic [1:0] flag, input logic [3:0] nb, input logic [7:0] dst);
    logic [133:0] w;
    w[127:0]   = {$urandom(), $urandom(), $urandom(), $urandom()};
    w[133:132] = flag;
    w[131:128] = nb;
    w[103:96]  = dst;
    return w;
  endfunction

  function automatic logic [1023:0] mk_phv();
    logic [1023:0] p;
    for (int i = 0; i < 32; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic d_word(input logic [133:0] w, input logic vwr, input logic [1023:0] p, input logic pwr);
    in_if.data = w; in_if.data_wr = 1'b1;
    in_if.valid = vwr; in_if.valid_wr = vwr;
    in_if.phv = p; in_if.phv_wr = pwr;
    @(posedge clk); #1;
    in_if.data_wr = 1'b0; in_if.valid_wr = 1'b0; in_if.phv_wr = 1'b0;
  endtask

  task automatic c_word(input logic [133:0] w);
    cin_wr_data = w; cin_wr_data_wr = 1'b1;
    @(posedge clk); #1;
    cin_wr_data_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [133:0] cfg_head(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    logic [133:0] w;
    w = mk_word(HEAD, 4'd0, LMID);
    w[127:124] = {1'b0, op};
    w[111:104] = SRC;
    w[95:64]   = addr;
    w[31:0]    = data;
    return w;
  endfunction

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    c_word(cfg_head(OP_WR, addr, data));
    c_word(mk_word(TAIL, 4'd0, 8'h00));
  endtask

  task automatic cfg_read(input logic [31:0] addr, input logic [31:0] val);
    logic [133:0] h, t, r;
    h = cfg_head(OP_RD, addr, 32'h0);
    t = mk_word(TAIL, 4'd0, 8'h00);
    r = h;
    r[127:124] = 4'b1011;
    r[111:104] = LMID;
    r[103:96]  = SRC;
    r[31:0]    = val;
    cfg_q.push_back(r);
    cfg_q.push_back(t);
    c_word(h);
    c_word(t);
    idle(2);
  endtask

  // n-word packet to dst; head carries a PHV, tail carries packet-valid.
  task automatic send_pkt(input int n, input logic [7:0] dst, input logic expect_fwd);
    for (int i = 0; i < n; i++) begin
      logic [1:0] f;
      logic [133:0] w;
      logic [1023:0] p;
      f = (i == 0) ? HEAD : (i == n - 1) ? TAIL : MID;
      w = mk_word(f, (i == n - 1) ? 4'd7 : 4'd0, dst);
      p = mk_phv();
      if (expect_fwd) out_q.push_back('{w, i == n - 1, i == n - 1, i == 0, p});
      d_word(w, i == n - 1, p, i == 0);
    end
    idle(2);
  endtask

  // n-word template to LMID; word 128 (index 127) becomes a forced tail if not one.
  task automatic send_tpl(input int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0] f;
      logic [133:0] w, fw;
      f = (i == 0) ? HEAD : (i == n - 1) ? TAIL : MID;
      w = mk_word(f, (i == n - 1) ? 4'd4 : 4'd0, (i == 0) ? LMID : 8'h00);
      if (i < 127 || (i == 127 && f == TAIL)) begin
        ram_q.push_back('{7'(i), {10'b0, w}});
      end else if (i == 127) begin
        fw = w; fw[133:132] = 2'b10; fw[131:128] = 4'd0;
        ram_q.push_back('{7'(127), {10'b0, fw}});
      end
      d_word(w, 1'b0, '0, 1'b0);
    end
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t rst_tbl[7];
    logic [133:0] h0, h1, c0, c1;
    rst_tbl = '{'{REG_START, 32'h0}, '{REG_TIME_LO, 32'h0}, '{REG_TIME_HI, 32'h0},
                '{REG_TLEN, 32'h0}, '{REG_DROP, 32'h0}, '{REG_STAT, 32'h0},
                '{32'h0002_0006, 32'hffff_ffff}};

    rst_n = 1'b0;
    in_if.data = '0; in_if.data_wr = 1'b0; in_if.valid = 1'b0; in_if.valid_wr = 1'b0;
    in_if.phv = '0; in_if.phv_wr = 1'b0;
    out_if.alf = 1'b0; out_if.phv_alf = 1'b0;
    cin_wr_data = '0; cin_wr_data_wr = 1'b0; cin_wr_ready = 1'b0;
    idle(3);
    chk("rst_bypass", pgm_bypass_flag, 1);
    chk("rst_start", pgm_sent_start_flag, 0);
    chk("rst_sent_time", out_wr_sent_time_reg, 0);
    chk("rst_strobes", {out_if.data_wr, out_if.valid_wr, out_if.phv_wr, wr2ram_wr, cout_wr_data_wr}, 0);
    rst_n = 1'b1;
    idle(2);

    out_if.alf = 1'b1; cin_wr_ready = 1'b1; #1;
    chk("alf_copy", in_if.alf, 1);
    chk("ready_copy", cout_wr_ready, 1);
    out_if.phv_alf = 1'b1; out_if.alf = 1'b0; #1;
    chk("phv_alf_copy", {in_if.phv_alf, in_if.alf}, 2'b10);
    out_if.phv_alf = 1'b0;
    idle(1);

    for (int i = 0; i < 7; i++) cfg_read(rst_tbl[i].addr, rst_tbl[i].val);

    // Start ignored without a template; unknown register reads all-ones.
    cfg_write(REG_START, 32'h1);
    idle(2);
    chk("start_no_tpl_flag", pgm_sent_start_flag, 0);
    cfg_read(REG_START, 32'h0);
    cfg_read(32'h0002_0099, 32'hffff_ffff);

    // Foreign cfg packet passes through unchanged.
    c0 = mk_word(HEAD, 4'd0, 8'h22); c0[126:124] = OP_WR;
    c1 = mk_word(TAIL, 4'd0, 8'h00);
    cfg_q.push_back(c0); cfg_q.push_back(c1);
    c_word(c0); c_word(c1); idle(2);

    // 4-word template.
    send_tpl(4);
    cfg_read(REG_TLEN, 32'd4);
    cfg_read(REG_STAT, 32'd2);

    // Oversize template truncates at 128 words.
    send_tpl(130);
    cfg_read(REG_TLEN, 32'd128);
    cfg_read(REG_STAT, 32'd6);

    // Stray non-head word in IDLE is ignored, then a bypass packet.
    d_word(mk_word(MID, 4'd0, 8'h05), 1'b0, '0, 1'b0);
    idle(2);
    send_pkt(3, 8'h05, 1'b1);

    // sent_time and start.
    cfg_write(REG_TIME_LO, 32'h0000_0020);
    cfg_write(REG_TIME_HI, 32'h0000_0001);
    c_word(cfg_head(OP_WR, REG_START, 32'h1));
    c_word(mk_word(TAIL, 4'd0, 8'h00));
    chk("start_flag", pgm_sent_start_flag, 1);
    chk("bypass_flag", pgm_bypass_flag, 0);
    chk("sent_time", out_wr_sent_time_reg, 64'h0000_0001_0000_0020);
    idle(2);
    cfg_read(REG_STAT, 32'd7);

    // Generating: packets are dropped and counted.
    send_pkt(3, 8'h05, 1'b0);
    cfg_read(REG_DROP, 32'd1);

    // Stop, then a start write racing a template head: store proceeds, start accepted.
    cfg_write(REG_START, 32'h0);
    idle(2);
    chk("stop_flag", pgm_bypass_flag, 1);
    h0 = mk_word(HEAD, 4'd0, LMID);
    h1 = mk_word(MID, 4'd0, 8'h00);
    ram_q.push_back('{7'd0, {10'b0, h0}});
    ram_q.push_back('{7'd1, {10'b0, h1}});
    fork
      begin d_word(h0, 1'b0, '0, 1'b0); d_word(h1, 1'b0, '0, 1'b0); end
      begin c_word(cfg_head(OP_WR, REG_START, 32'h1)); c_word(mk_word(TAIL, 4'd0, 8'h00)); end
    join
    chk("race_start_flag", pgm_sent_start_flag, 1);

    // Reset in the middle of STORE.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bypass", pgm_bypass_flag, 1);
    chk("mid_rst_start", pgm_sent_start_flag, 0);
    chk("mid_rst_ram", {wr2ram_wr, wr2ram_addr}, 0);
    chk("mid_rst_time", out_wr_sent_time_reg, 0);
    chk("mid_rst_out", {out_if.data_wr, cout_wr_data_wr}, 0);
    chk("ram_q_drained", ram_q.size(), 0);
    #10;
    rst_n = 1'b1;
    idle(2);
    cfg_read(REG_STAT, 32'd0);
    send_tpl(2);
    cfg_read(REG_TLEN, 32'd2);

    idle(4);
    chk("out_q_empty", out_q.size(), 0);
    chk("ram_q_empty", ram_q.size(), 0);
    chk("cfg_q_empty", cfg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pgm_wr.md
Name: pgm_wr

Overview:
- Front stage of the packet generator (PGM), directly upstream of pgm_rd.
- Classifies incoming data-plane packets:
  - Template packets addressed to this module are written word-by-word into PGM_RAM.
  - All other packets are forwarded to pgm_rd with 1-cycle latency while bypass is active.
- Owns the generator control registers (start, sent_time) on the configuration chain and drives pgm_bypass_flag, pgm_sent_start_flag and the sent_time value into pgm_rd.

Parameters:
- PLATFORM, "Xilinx", target vendor tag (unused in logic).
- LMID, 8'd61, own MID; template packets and cfg packets carrying this MID are consumed here.
- NMID, 8'd62, next MID (pgm_rd); informational.
- RAM_DEPTH, 128, PGM_RAM words (address width 7).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_wr_data  in  134  data word; [133:132] 01 head / 11 middle / 10 tail; [131:128] valid bytes of tail; head [103:96] destination MID.
- in_wr_data_wr  in  1  data word strobe.
- in_wr_valid  in  1  packet-valid flag.
- in_wr_valid_wr  in  1  valid strobe.
- in_wr_phv  in  1024  PHV.
- in_wr_phv_wr  in  1  PHV strobe.
- out_wr_alf  out  1  almost-full to upstream; combinational copy of in_wr_alf.
- out_wr_phv_alf  out  1  combinational copy of in_wr_phv_alf.
- out_wr_data / out_wr_data_wr / out_wr_valid / out_wr_valid_wr / out_wr_phv / out_wr_phv_wr  out  134/1/1/1/1024/1  registered stream to pgm_rd.
- in_wr_alf, in_wr_phv_alf  in  1  backpressure from pgm_rd.
- pgm_bypass_flag  out  1  to pgm_rd; high when not generating.
- pgm_sent_start_flag  out  1  to pgm_rd; level start request.
- out_wr_sent_time_reg  out  64  generation duration in cycles.
- wr2ram_wr  out  1  RAM write enable.
- wr2ram_addr  out  7  RAM write address.
- wr2ram_wdata  out  144  {10'b0, word[133:0]}.
- cin_wr_data  in  134  cfg chain input.
- cin_wr_data_wr  in  1  cfg chain input strobe.
- cout_wr_ready  out  1  combinational copy of cin_wr_ready.
- cout_wr_data  out  134  registered cfg chain output.
- cout_wr_data_wr  out  1  registered cfg chain output strobe.
- cin_wr_ready  in  1  ready from next cfg stage.

Behaviour:

Reset
- All registered outputs, counters and registers are 0.
- pgm_bypass_flag resets to 1; FSM resets to IDLE.

Flags
- pgm_sent_start_flag = start_reg (registered).
- pgm_bypass_flag = ~start_reg (registered).

FSM IDLE / STORE / BYPASS / DROP; only transitions on in_wr_data_wr=1 words are listed.
- IDLE, head (01):
  - Dst==LMID and start_reg=0 → write word at addr 0, wptr=1, template_valid=0, STORE.
  - Dst==LMID and start_reg=1 → drop_cnt+1, DROP (RAM is being read).
  - Dst!=LMID and start_reg=0 → forward, BYPASS.
  - Dst!=LMID and start_reg=1 → drop_cnt+1, DROP.
- STORE:
  - Each word is written at wptr, wptr+1.
  - Tail (10) → template_len=wptr+1, template_valid=1, IDLE.
  - wptr==127 and word not tail → write it with [133:132] forced to 10 and [131:128]=0, set trunc, template_valid=1, len=128, DROP.
- BYPASS:
  - Forward each word, registered with 1-cycle latency, copying data/valid/phv and their strobes.
  - Tail → IDLE.
- DROP: discard words until tail → IDLE.
- Non-head word in IDLE: ignored.
- Cycles with in_wr_data_wr=0: all output strobes 0.
- wr2ram_* is registered (1-cycle latency from input word).

Cfg chain (2-word packets, header on head word)
- Head word with [103:96]==LMID, [126:124]=010 (write) → register write; both words consumed (cout_wr_data_wr=0).
  - 0x00020000: start_reg=bit0. Set only if template_valid, otherwise ignored.
  - 0x00020001: sent_time[31:0].
  - 0x00020002: sent_time[63:32].
- [126:124]=001 (read) → reply on the same cycle slot.
  - Reply head word: [127:124]=1011, src and dst MID bytes swapped, [31:0] = register value.
  - 0x00020000 start; 0x00020001/2 sent_time halves; 0x00020003 template_len; 0x00020004 drop_cnt; 0x00020005 {29'b0, trunc, template_valid, start_reg}; other addresses → 32'hffffffff.
  - Tail word is passed through.
- Any other cfg word: passed through with 1-cycle latency.

Simultaneous events
- A cfg start write in the same cycle as a data head to LMID: the data path samples the old start_reg (store proceeds).
- The start write applies next cycle and is accepted if template_valid was already 1.

Counters
- drop_cnt: 32-bit, saturates at 32'hffffffff.
- wptr: never wraps.

Decomposition:
- Shared package pgm_pkg holds:
  - Flag constants HEAD/MID/TAIL.
  - Cfg op codes WR=3'b010, RD=3'b001, RSP=4'b1011.
  - Register addresses 0x0002000x.
  - RAM_AW=7.
- One sub-module pgm_wr_cfg (cfg chain register file and reply builder). The FSM/datapath stays in pgm_wr.

Test Plan:
1. 4-word template (01,11,11,10 with [131:128]=4) to LMID → RAM addr 0..3 written with identical words, template_len reads 4, template_valid=1, no out_wr_data_wr.
2. Cfg write sent_time=0x0000000100000020, then start=1 → out_wr_sent_time_reg=0x100000020, pgm_sent_start_flag=1, pgm_bypass_flag=0 the cycle after write tail.
3. 3-word packet to MID 0x05 with start_reg=0 → identical 3 words on out_wr_data one cycle later with out_wr_valid=1 on tail; same packet with start_reg=1 → nothing forwarded, drop_cnt=1.
4. 130-word template → addr 127 holds forced tail flag 10, trunc=1, len=128, words 129-130 discarded, FSM back to IDLE after tail.
5. Start write with template_valid=0 → start stays 0; cfg read 0x00020099 → reply data 32'hffffffff with MID bytes swapped.
6. rst_n low mid-STORE (word 2) → all outputs 0, bypass=1, template_valid=0; subsequent head restarts at addr 0.
